// File: rtl/db_fetch_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : db_fetch_sched
//  Description : DDR read scheduler for the BLAST pipeline. Streams database
//                blocks in order into a prefetch FIFO for the hit stage and
//                serves random-address expand reads, which take priority.
//                One DDR read is outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module db_fetch_sched #(
    parameter int                    ADDR_W     = 32,
    parameter int                    DATA_W     = 512,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_W-1:0]     BASE_ADDR  = '0,
    parameter longint unsigned       NUM_BLOCKS = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    output logic              ddr_rd,
    output logic [ADDR_W-1:0] readAdd,
    input  logic              ddr_rd_valid,
    input  logic              ddr_rd_done,
    input  logic [DATA_W-1:0] ddr_rd_data,
    output logic [DATA_W-1:0] db_data,
    output logic              db_last,
    output logic              db_valid,
    input  logic              db_ready,
    input  logic              exp_req,
    input  logic [ADDR_W-1:0] exp_addr,
    output logic [DATA_W-1:0] exp_data,
    output logic              exp_valid,
    output logic              busy,
    output logic              done
);

    localparam int              c_PTR_W  = $clog2(DEPTH);
    localparam int              c_CNT_W  = c_PTR_W + 1;
    localparam logic [ADDR_W-1:0]  c_NUM    = ADDR_W'(NUM_BLOCKS);
    localparam logic [ADDR_W-1:0]  c_LAST   = ADDR_W'(NUM_BLOCKS - 1);
    localparam logic [ADDR_W-1:0]  c_STRIDE = ADDR_W'(DATA_W);
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ARB      = 3'd1;
    localparam logic [2:0] c_SEQ_WAIT = 3'd2;
    localparam logic [2:0] c_EXP_WAIT = 3'd3;
    localparam logic [2:0] c_DRAIN    = 3'd4;

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_seqIdx;
    logic                r_started;
    logic                r_ddrRd;
    logic [ADDR_W-1:0]   r_readAdd;
    logic [DATA_W:0]     r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wrPtr;
    logic [c_PTR_W-1:0]  r_rdPtr;
    logic [c_CNT_W-1:0]  r_count;
    logic [DATA_W-1:0]   r_dbData;
    logic                r_dbLast;
    logic                r_dbValid;
    logic [DATA_W-1:0]   r_expData;
    logic                r_expValid;
    logic                r_busy;
    logic                r_done;

    logic                w_resp;
    logic                w_active;
    logic                w_seqOk;
    logic [ADDR_W-1:0]   w_seqAddr;
    logic [2:0]          w_nextState;
    logic                w_issueExp;
    logic                w_issueSeq;
    logic                w_push;
    logic                w_pop;
    logic                w_expResp;
    logic                w_pushLast;
    logic [c_CNT_W-1:0]  w_countNext;
    logic [c_PTR_W-1:0]  w_headIdx;
    logic                w_bypass;

    assign w_resp     = ddr_rd_valid & ddr_rd_done;
    // The stream stays active until every block has been issued and returned.
    assign w_active   = r_started && (r_seqIdx != c_NUM);
    // Only one read is in flight and ARB has none, so the count is the reservation.
    assign w_seqOk    = w_active && (r_count < c_DEPTH);
    assign w_seqAddr  = BASE_ADDR + r_seqIdx * c_STRIDE;
    assign w_pushLast = (r_seqIdx == c_LAST);
    assign w_pop      = db_ready && (r_count != '0) && !flush;
    assign w_countNext = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_headIdx  = w_pop ? r_rdPtr + c_PTR_W'(1) : r_rdPtr;
    // A push into a FIFO that is (or becomes) empty this cycle is the new head.
    assign w_bypass   = w_push && (r_count == c_CNT_W'(w_pop));

    // Next-state and issue decisions; flush overrides everything below rst.
    always_comb begin
        w_nextState = r_state;
        w_issueExp  = 1'b0;
        w_issueSeq  = 1'b0;
        w_push      = 1'b0;
        w_expResp   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start || exp_req) w_nextState = c_ARB;
            end
            c_ARB: begin
                if (exp_req) begin
                    w_issueExp  = 1'b1;
                    w_nextState = c_EXP_WAIT;
                end else if (w_seqOk) begin
                    w_issueSeq  = 1'b1;
                    w_nextState = c_SEQ_WAIT;
                end else if (!w_active) begin
                    w_nextState = c_IDLE;
                end
            end
            c_SEQ_WAIT: begin
                if (w_resp) begin
                    w_push      = 1'b1;
                    w_nextState = c_ARB;
                end
            end
            c_EXP_WAIT: begin
                if (w_resp) begin
                    w_expResp   = 1'b1;
                    w_nextState = c_ARB;
                end
            end
            c_DRAIN: begin
                if (w_resp) w_nextState = c_IDLE;
            end
            default: w_nextState = c_IDLE;
        endcase
        if (flush) begin
            w_issueExp = 1'b0;
            w_issueSeq = 1'b0;
            w_push     = 1'b0;
            w_expResp  = 1'b0;
            // A response arriving with the flush already retires the read, so
            // there is nothing left to drain.
            if ((r_state == c_SEQ_WAIT || r_state == c_EXP_WAIT || r_state == c_DRAIN) && !w_resp)
                w_nextState = c_DRAIN;
            else
                w_nextState = c_IDLE;
        end
    end

    // Control state, DDR request, expand response and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_seqIdx   <= '0;
            r_started  <= 1'b0;
            r_ddrRd    <= 1'b0;
            r_readAdd  <= '0;
            r_expData  <= '0;
            r_expValid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_busy     <= (w_nextState != c_IDLE);
            r_ddrRd    <= w_issueExp | w_issueSeq;
            if (w_issueExp)      r_readAdd <= exp_addr;
            else if (w_issueSeq) r_readAdd <= w_seqAddr;
            r_expValid <= w_expResp;
            if (w_expResp) r_expData <= ddr_rd_data;
            if (flush) begin
                r_seqIdx  <= '0;
                r_started <= 1'b0;
                r_done    <= 1'b0;
            end else if (start && r_state == c_IDLE) begin
                r_seqIdx  <= '0;
                r_started <= 1'b1;
                r_done    <= 1'b0;
            end else begin
                if (w_push) r_seqIdx <= r_seqIdx + ADDR_W'(1);
                if (r_started && r_seqIdx == c_NUM && r_count == '0) r_done <= 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy and the registered head presented to the hit stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_dbData  <= '0;
            r_dbLast  <= 1'b0;
            r_dbValid <= 1'b0;
        end else if (flush) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_dbLast  <= 1'b0;
            r_dbValid <= 1'b0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            if (w_pop)  r_rdPtr <= w_headIdx;
            r_count   <= w_countNext;
            r_dbValid <= (w_countNext != '0);
            if (w_countNext == '0)
                r_dbLast <= 1'b0;
            else if (w_bypass)
                {r_dbLast, r_dbData} <= {w_pushLast, ddr_rd_data};
            else
                {r_dbLast, r_dbData} <= r_mem[w_headIdx];
        end
    end

    // FIFO storage; contents are qualified by the count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= {w_pushLast, ddr_rd_data};
    end

    assign ddr_rd    = r_ddrRd;
    assign readAdd   = r_readAdd;
    assign db_data   = r_dbData;
    assign db_last   = r_dbLast;
    assign db_valid  = r_dbValid;
    assign exp_data  = r_expData;
    assign exp_valid = r_expValid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
